led_fade_pwm: RTL and testbench

- Downstream output stage for the LED pattern generators: the rotating 2-LED pattern and the progressive fill/empty patterns.
- Takes the 8-bit on/off pattern and drives the physical LED pins with PWM.
- Each LED fades up or down in brightness instead of switching hard; hard edges become smooth ramps.
- Sits between the pattern register and the board LED pins.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_fade_chan.sv | 65 ++++++
 rtl/led_fade_pwm.sv | 71 +++++++
 tb/tb_led_fade_pwm.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and helpers for the LED fade stage; LED_GAMMA_EN adds led_gamma
package led_pkg;

   localparam int LED_N     = 8;
   localparam int LED_PWM_W = 4;

   // Brightest level for a given level width; the PWM period is this many cycles.
   function automatic int led_maxl(input int pwm_w);
      return (1 << pwm_w) - 1;
   endfunction

`ifdef LED_GAMMA_EN
   // Square-law brightness curve rounded up, so only level 0 is fully dark.
   // The square of a PWM_W-bit level always fits in 2*PWM_W bits.
   function automatic int led_gamma(input int level, input int maxl);
      return (level * level + maxl - 1) / maxl;
   endfunction
`endif

endpackage

// File: rtl/led_fade_chan.sv
// rtl/led_fade_chan.sv - one LED channel: saturating fade level and PWM compare (LED_GAMMA_EN selects gamma compare)
module led_fade_chan
   import led_pkg::*;
#(
   parameter int PWM_W = LED_PWM_W
) (
   input  logic             clk,
   input  logic             rs,
   input  logic             target,
   input  logic             fade_tick,
   input  logic [PWM_W-1:0] pwm_cnt,
   output logic             pin,
   output logic             at_target
);

   localparam int               MAXL   = led_maxl(PWM_W);
   localparam logic [PWM_W-1:0] MAXL_V = PWM_W'(MAXL);

   logic [PWM_W-1:0] level_q;
   logic [PWM_W-1:0] level_d;
   logic [PWM_W-1:0] cmp_level;
   logic             pin_q;
   logic             pin_d;

   // Step the level one notch toward the target on each fade tick, clamped at both ends.
   always_comb begin
      level_d = level_q;
      if (fade_tick) begin
         if (target && (level_q != MAXL_V)) begin
            level_d = level_q + PWM_W'(1);
         end else if (!target && (level_q != '0)) begin
            level_d = level_q - PWM_W'(1);
         end
      end
   end

   // Brightness value fed to the comparator: raw level, or its gamma-corrected form.
   always_comb begin
`ifdef LED_GAMMA_EN
      cmp_level = PWM_W'(led_gamma(int'(level_q), MAXL));
`else
      cmp_level = level_q;
`endif
   end

   // PWM compare; level 0 never exceeds the counter and MAXL always does.
   always_comb begin
      pin_d = (cmp_level > pwm_cnt);
   end

   // Level and pin registers.
   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         level_q <= '0;
         pin_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         pin_q   <= pin_d;
      end
   end

   assign pin       = pin_q;
   assign at_target = target ? (level_q == MAXL_V) : (level_q == '0);

endmodule

// File: rtl/led_fade_pwm.sv
// rtl/led_fade_pwm.sv - PWM fade output stage for the LED pattern (LED_GAMMA_EN selects gamma compare)
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int N        = LED_N,
   parameter int PWM_W    = LED_PWM_W,
   parameter int FADE_DIV = 1024
) (
   input  logic         clk,
   input  logic         rs,
   input  logic [N-1:0] led_in,
   output logic [N-1:0] led_out,
   output logic         busy
);

   localparam int MAXL  = led_maxl(PWM_W);
   localparam int DIV_W = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;

   logic [N-1:0]     led_in_q;
   logic [N-1:0]     led_in_d;
   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;
   logic [PWM_W-1:0] pwm_cnt_q;
   logic [PWM_W-1:0] pwm_cnt_d;
   logic             busy_q;
   logic             busy_d;
   logic             fade_tick;
   logic [N-1:0]     at_target;

   assign fade_tick = (div_cnt_q == DIV_W'(FADE_DIV - 1));

   // Next-state for the input register, fade prescaler, free-running PWM counter and busy flag.
   always_comb begin
      led_in_d  = led_in;
      div_cnt_d = fade_tick ? '0 : div_cnt_q + DIV_W'(1);
      pwm_cnt_d = (pwm_cnt_q == PWM_W'(MAXL - 1)) ? '0 : pwm_cnt_q + PWM_W'(1);
      busy_d    = ~(&at_target);
   end

   // Shared control registers.
   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         led_in_q  <= '0;
         div_cnt_q <= '0;
         pwm_cnt_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         led_in_q  <= led_in_d;
         div_cnt_q <= div_cnt_d;
         pwm_cnt_q <= pwm_cnt_d;
         busy_q    <= busy_d;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_chan
      led_fade_chan #(
         .PWM_W(PWM_W)
      ) u_chan (
         .clk      (clk),
         .rs       (rs),
         .target   (led_in_q[i]),
         .fade_tick(fade_tick),
         .pwm_cnt  (pwm_cnt_q),
         .pin      (led_out[i]),
         .at_target(at_target[i])
      );
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb/tb_led_fade_pwm.sv - self-checking bench for led_fade_pwm (LED_GAMMA_EN selects gamma model)
module tb_led_fade_pwm;

   localparam int N        = 8;
   localparam int PWM_W    = 4;
   localparam int FADE_DIV = 4;
   localparam int MAXL     = 15;

   logic         clk = 1'b0;
   logic         rs;
   logic [N-1:0] led_in;
   logic [N-1:0] led_out;
   logic         busy;

   int compared   = 0;
   int mismatched = 0;

   int           m_lvl[N];
   logic [N-1:0] m_inq;
   logic [N-1:0] m_out;
   logic         m_busy;
   int           m_k;

   always #5 clk = ~clk;

   led_fade_pwm #(
      .N(N),
      .PWM_W(PWM_W),
      .FADE_DIV(FADE_DIV)
   ) dut (
      .clk    (clk),
      .rs     (rs),
      .led_in (led_in),
      .led_out(led_out),
      .busy   (busy)
   );

   function automatic int eff(input int l);
`ifdef LED_GAMMA_EN
      return (l * l + MAXL - 1) / MAXL;
`else
      return l;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_lvl[i] = 0;
      m_inq  = '0;
      m_out  = '0;
      m_busy = 1'b0;
      m_k    = 0;
   endtask

   // Model of one clock edge: k counts edges since reset, so the PWM phase is
   // k mod MAXL and a fade step happens when k mod FADE_DIV is FADE_DIV-1.
   task automatic model_step();
      int           ph;
      bit           tick;
      logic [N-1:0] o;
      logic         b;
      ph   = m_k % MAXL;
      tick = ((m_k % FADE_DIV) == FADE_DIV - 1);
      o    = '0;
      b    = 1'b0;
      for (int i = 0; i < N; i++) begin
         o[i] = (eff(m_lvl[i]) > ph);
         if (m_inq[i] ? (m_lvl[i] != MAXL) : (m_lvl[i] != 0)) b = 1'b1;
      end
      if (tick) begin
         for (int i = 0; i < N; i++) begin
            if (m_inq[i]) m_lvl[i] = (m_lvl[i] < MAXL) ? m_lvl[i] + 1 : MAXL;
            else          m_lvl[i] = (m_lvl[i] > 0) ? m_lvl[i] - 1 : 0;
         end
      end
      m_out  = o;
      m_busy = b;
      m_inq  = led_in;
      m_k    = m_k + 1;
   endtask

   task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      if (rs) model_reset();
      else    model_step();
      @(negedge clk);
      chk_vec({tag, "_out"}, led_out, m_out);
      chk_bit({tag, "_busy"}, busy, m_busy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rs = 1'b1;
      @(negedge clk);
      rs = 1'b0;
      model_reset();
   endtask

   initial begin
      int  guard;
      logic [N-1:0] rot;

      // 1: reset held with all targets on
      rs     = 1'b1;
      led_in = 8'hFF;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         chk_vec("rst_out", led_out, 8'h00);
         chk_bit("rst_busy", busy, 1'b0);
      end
      rs = 1'b0;
      repeat (70) cycle("ramp_all");
      repeat (15) begin
         cycle("full_all");
         chk_vec("full_all_on", led_out, 8'hFF);
         chk_bit("full_all_idle", busy, 1'b0);
      end

      // 2: ramp two channels to full
      do_reset();
      led_in = 8'h03;
      repeat (70) cycle("ramp03");
      repeat (15) begin
         cycle("full03");
         chk_vec("full03_on", led_out, 8'h03);
         chk_bit("full03_idle", busy, 1'b0);
      end

      // 3: reverse mid-ramp at level 7, must floor at 0
      do_reset();
      led_in = 8'h01;
      guard  = 0;
      while (m_lvl[0] != 7 && guard < 100) begin
         cycle("rev_up");
         guard++;
      end
      chk_bit("rev_reach7", (m_lvl[0] == 7), 1'b1);
      led_in = 8'h00;
      repeat (32) cycle("rev_down");
      repeat (20) begin
         cycle("rev_floor");
         chk_vec("rev_floor_off", led_out, 8'h00);
         chk_bit("rev_floor_idle", busy, 1'b0);
      end

      // 4: upstream rotation every two ticks keeps the stage busy
      do_reset();
      rot    = 8'h03;
      led_in = rot;
      repeat (2) cycle("rot_start");
      for (int r = 0; r < 10; r++) begin
         repeat (2 * FADE_DIV) begin
            cycle("rot");
            chk_bit("rot_busy", busy, 1'b1);
         end
         rot    = {rot[N-2:0], rot[N-1]};
         led_in = rot;
      end

      // 5: asynchronous reset between edges at level 9
      do_reset();
      led_in = 8'h01;
      guard  = 0;
      while (m_lvl[0] != 9 && guard < 100) begin
         cycle("ar_up");
         guard++;
      end
      chk_bit("ar_reach9", (m_lvl[0] == 9), 1'b1);
      #1 rs = 1'b1;
      #1;
      chk_vec("ar_out", led_out, 8'h00);
      chk_bit("ar_busy", busy, 1'b0);
      model_reset();
      @(negedge clk);
      rs = 1'b0;
      model_reset();
      repeat (40) cycle("ar_restart");

      // randomized targets held for random stretches
      do_reset();
      repeat (40) begin
         led_in = N'($urandom);
         repeat ($urandom_range(1, 20)) cycle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
